dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
// Control FSM for the direct-mapped, write-allocate, write-back data cache.
// - Sits between the CPU load/store port, the data_cache_sram block array and
//   the block-wide DRAM port.
// - Owns the tag, valid and dirty arrays; drives the SRAM index/write strobe.
// - Performs victim write-back and block refill with a req/ready handshake.
// PARAMETERS
// ADDR_W       16  CPU word-address width
// WORD_W       16  data word width (matches DRAM_WORD_SIZE)
// BLOCK_WORDS   4  words per block (power of 2; OFF_W = log2(BLOCK_WORDS) = 2)
// INDEX_W       4  cache index width (2**INDEX_W lines)
// TAG_W  ADDR_W-INDEX_W-OFF_W (derived, 10)  stored tag width
// PORTS
// clk         in   1                    clock, rising edge
// rst_n       in   1                    async active-low reset
// cpu_req     in   1                    access request, held until cpu_ready
// cpu_we      in   1                    1=store, 0=load
// cpu_addr    in   ADDR_W               word address = {tag,index,offset}
// cpu_wdata   in   WORD_W               store data
// cpu_rdata   out  WORD_W               load data, valid when cpu_ready
// cpu_ready   out  1                    1-cycle completion pulse
// sram_we     out  1                    block write strobe to SRAM
// sram_index  out  INDEX_W              SRAM line index
// sram_wdata  out  WORD_W x BLOCK_WORDS block to write into SRAM
// sram_rdata  in   WORD_W x BLOCK_WORDS combinational SRAM read of sram_index
// mem_req     out  1                    DRAM request, held until mem_ready
// mem_we      out  1                    1=write-back, 0=refill read
// mem_addr    out  ADDR_W-OFF_W         DRAM block address
// mem_wdata   out  WORD_W x BLOCK_WORDS victim block
// mem_rdata   in   WORD_W x BLOCK_WORDS refill block, valid with mem_ready
// mem_ready   in   1                    DRAM completion, 1-cycle pulse
// BEHAVIOUR
// Reset (async):
// - State = IDLE; all valid and dirty bits cleared.
// - All outputs 0. SRAM contents untouched.
// - An in-flight DRAM transaction is abandoned: mem_req drops immediately.
// IDLE:
// - cpu_req=1: latch addr/we/wdata, go to COMPARE.
// - cpu_req is sampled only in IDLE.
// - sram_index always = latched index (IDLE: cpu_addr index).
// COMPARE: hit = valid[idx] && tag[idx]==latched tag.
// - Hit load: cpu_rdata = sram_rdata[offset], cpu_ready=1, go to IDLE.
// - Hit store: sram_we=1, sram_wdata = sram_rdata with word[offset] replaced
//   by wdata; dirty[idx]<=1; cpu_ready=1; go to IDLE.
// - Miss with valid && dirty: go to WRITEBACK.
// - Miss otherwise: go to ALLOCATE.
// WRITEBACK:
// - mem_req=1, mem_we=1, mem_addr={tag[idx],idx}, mem_wdata=sram_rdata.
// - Hold until mem_ready, then go to ALLOCATE; dirty[idx]<=0.
// ALLOCATE:
// - mem_req=1, mem_we=0, mem_addr={latched tag,idx}.
// - On mem_ready: sram_we=1, sram_wdata=mem_rdata, tag[idx]<=latched tag,
//   valid<=1, dirty<=0; go to COMPARE. The access re-checks and hits.
// Handshakes:
// - mem_req, mem_addr and mem_wdata are stable while waiting.
// - mem_req is low in the cycle after mem_ready.
// - mem_ready outside WRITEBACK/ALLOCATE is ignored.
// Latency:
// - Hit: cpu_ready 1 cycle after cpu_req is sampled.
// - Clean miss: +1 +DRAM latency +1.
// - Dirty miss: adds one extra DRAM transaction.
// Constraints:
// - No back-to-back accept in the cpu_ready cycle; the next request is
//   sampled in IDLE.
// - Offset selects the word within the block; address bits above ADDR_W
//   do not exist.
// TESTING
// 1. Reset, load 0x0010 -> miss, mem_addr=0x004, mem_we=0; refill; cpu_ready with word 0 of block.
// 2. Reload 0x0011 -> hit, cpu_ready exactly 1 cycle after req; no mem_req.
// 3. Store 0xBEEF to 0x0012, then load 0x0012 -> 0xBEEF; dirty set; no DRAM traffic.
// 4. Load 0x0412 (same index 4, new tag) -> write-back at mem_addr=0x004
//    with word2=0xBEEF, then refill mem_addr=0x104.
// 5. Assert rst_n low during ALLOCATE wait -> mem_req=0 at once; next load to 0x0010 misses.
// 6. Hold mem_ready low 20 cycles -> mem_req/mem_addr stable; cpu_ready stays 0.

Source files
------------

// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
// Control FSM for a direct-mapped, write-allocate, write-back data cache.
// Sits between the CPU load/store port, the block-wide SRAM data array and a
// block-wide DRAM port. Owns the tag/valid/dirty state, drives the SRAM
// index and write strobe, and runs victim write-back and refill transactions
// over a req/ready handshake.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_cpu_req/we/addr/wdata   CPU request; held by the CPU until o_cpu_ready
//   o_cpu_rdata/o_cpu_ready   load data and 1-cycle completion pulse
//   o_sram_we/index/wdata     block write port of the SRAM data array
//   i_sram_rdata              combinational SRAM read of o_sram_index
//   o_mem_req/we/addr/wdata   DRAM block request (held until i_mem_ready)
//   i_mem_rdata/i_mem_ready   refill data and 1-cycle DRAM completion pulse
// -----------------------------------------------------------------------------
module dcache_controller #(
  parameter int ADDR_W      = 16,
  parameter int WORD_W      = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int INDEX_W     = 4,
  localparam int OFF_W      = $clog2(BLOCK_WORDS),
  localparam int TAG_W      = ADDR_W - INDEX_W - OFF_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_cpu_req,
  input  logic                                i_cpu_we,
  input  logic [ADDR_W-1:0]                   i_cpu_addr,
  input  logic [WORD_W-1:0]                   i_cpu_wdata,
  output logic [WORD_W-1:0]                   o_cpu_rdata,
  output logic                                o_cpu_ready,
  output logic                                o_sram_we,
  output logic [INDEX_W-1:0]                  o_sram_index,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]  o_sram_wdata,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  i_sram_rdata,
  output logic                                o_mem_req,
  output logic                                o_mem_we,
  output logic [ADDR_W-OFF_W-1:0]             o_mem_addr,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]  o_mem_wdata,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  i_mem_rdata,
  input  logic                                i_mem_ready
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t                               r_state;
  logic [TAG_W-1:0]                     r_tag;
  logic [INDEX_W-1:0]                   r_idx;
  logic [OFF_W-1:0]                     r_off;
  logic                                 r_we;
  logic [WORD_W-1:0]                    r_wdata;
  logic [LINES-1:0]                     r_valid;
  logic [LINES-1:0]                     r_dirty;
  logic [TAG_W-1:0]                     r_tags [LINES];
  logic                                 r_mem_req;
  logic                                 r_mem_we;
  logic [ADDR_W-OFF_W-1:0]              r_mem_addr;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   r_mem_wdata;

  logic                                 w_hit;
  logic                                 w_refill_done;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   w_merged;

  // In IDLE the SRAM already looks at the incoming index, so the block is
  // on i_sram_rdata by the time COMPARE runs.
  assign o_sram_index = (r_state == S_IDLE) ? i_cpu_addr[OFF_W +: INDEX_W] : r_idx;

  assign w_hit = (r_state == S_COMPARE) && r_valid[r_idx] && (r_tags[r_idx] == r_tag);

  // r_mem_req gates completion so a stray ready pulse while the request is
  // not yet (re)raised cannot complete a transaction.
  assign w_refill_done = (r_state == S_ALLOCATE) && r_mem_req && i_mem_ready;

  // Store merge: the addressed word takes the CPU data, others keep SRAM data.
  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_merge
      assign w_merged[gi] = (r_off == OFF_W'(gi)) ? r_wdata : i_sram_rdata[gi];
    end
  endgenerate

  assign o_cpu_ready  = w_hit;
  assign o_cpu_rdata  = (w_hit && !r_we) ? i_sram_rdata[r_off] : '0;
  assign o_sram_we    = (w_hit && r_we) || w_refill_done;
  assign o_sram_wdata = w_refill_done  ? i_mem_rdata :
                        (w_hit && r_we) ? w_merged    : '0;

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  // Tag array needs no reset: a tag is only meaningful when its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_refill_done) begin
      r_tags[r_idx] <= r_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tag       <= '0;
      r_idx       <= '0;
      r_off       <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req) begin
            r_tag   <= i_cpu_addr[ADDR_W-1 -: TAG_W];
            r_idx   <= i_cpu_addr[OFF_W +: INDEX_W];
            r_off   <= i_cpu_addr[OFF_W-1:0];
            r_we    <= i_cpu_we;
            r_wdata <= i_cpu_wdata;
            r_state <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          if (w_hit) begin
            if (r_we) begin
              r_dirty[r_idx] <= 1'b1;
            end
            r_state <= S_IDLE;
          end else if (r_valid[r_idx] && r_dirty[r_idx]) begin
            // Victim block is on i_sram_rdata now; capture it so the DRAM
            // sees a stable write-back payload for the whole wait.
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {r_tags[r_idx], r_idx};
            r_mem_wdata <= i_sram_rdata;
            r_state     <= S_WRITEBACK;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {r_tag, r_idx};
            r_mem_wdata <= '0;
            r_state     <= S_ALLOCATE;
          end
        end

        S_WRITEBACK: begin
          if (r_mem_req && i_mem_ready) begin
            // Request drops for one cycle; ALLOCATE re-raises it.
            r_mem_req      <= 1'b0;
            r_dirty[r_idx] <= 1'b0;
            r_state        <= S_ALLOCATE;
          end
        end

        S_ALLOCATE: begin
          if (r_mem_req) begin
            if (i_mem_ready) begin
              r_mem_req      <= 1'b0;
              r_valid[r_idx] <= 1'b1;
              r_dirty[r_idx] <= 1'b0;
              r_state        <= S_COMPARE;
            end
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {r_tag, r_idx};
            r_mem_wdata <= '0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cpu_req;
  logic                cpu_we;
  logic [15:0]         cpu_addr;
  logic [15:0]         cpu_wdata;
  logic [15:0]         cpu_rdata;
  logic                cpu_ready;
  logic                sram_we;
  logic [3:0]          sram_index;
  logic [3:0][15:0]    sram_wdata;
  logic [3:0][15:0]    sram_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [13:0]         mem_addr;
  logic [3:0][15:0]    mem_wdata;
  logic [3:0][15:0]    mem_rdata;
  logic                mem_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int dram_lat = 3;

  logic        q_we    [$];
  logic [13:0] q_addr  [$];
  logic [63:0] q_wdata [$];

  logic [3:0][15:0] sram_mem [16];

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_rdata  (cpu_rdata),
    .o_cpu_ready  (cpu_ready),
    .o_sram_we    (sram_we),
    .o_sram_index (sram_index),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_mem_ready  (mem_ready)
  );

  // SRAM model: combinational read, synchronous block write.
  assign sram_rdata = sram_mem[sram_index];
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_index] <= sram_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // DRAM content: each word is its own word address XOR 0x5000.
  function automatic logic [3:0][15:0] dram_block(input logic [13:0] ba);
    logic [3:0][15:0] b;
    for (int g = 0; g < 4; g++) b[g] = {ba, 2'(g)} ^ 16'h5000;
    return b;
  endfunction

  // DRAM responder: logs each request, holds ready low for dram_lat-1 extra
  // cycles while checking the request stays stable, then pulses ready.
  initial begin
    logic        c_we;
    logic [13:0] c_addr;
    logic [63:0] c_wd;
    logic        stable, early, abandoned;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && rst_n === 1'b1) begin
        c_we = mem_we; c_addr = mem_addr; c_wd = mem_wdata;
        q_we.push_back(c_we); q_addr.push_back(c_addr); q_wdata.push_back(c_wd);
        stable = 1'b1; early = 1'b0; abandoned = 1'b0;
        for (int k = 1; k < dram_lat; k++) begin
          @(negedge clk);
          if (mem_req !== 1'b1) begin
            abandoned = 1'b1;
            break;
          end
          if (mem_we !== c_we || mem_addr !== c_addr || mem_wdata !== c_wd) stable = 1'b0;
          if (cpu_ready !== 1'b0) early = 1'b1;
        end
        if (!abandoned) begin
          mem_rdata = dram_block(c_addr);
          mem_ready = 1'b1;
          @(negedge clk);
          mem_ready = 1'b0;
          chk("mem_stable", 64'(stable), 64'd1);
          chk("no_early_ready", 64'(early), 64'd0);
          chk("mem_req_drop", 64'(mem_req), 64'd0);
        end
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd, output int cyc,
                            output logic swe, output logic [63:0] swd);
    logic got;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    cyc = 0; got = 1'b0; rd = '0; swe = 1'b0; swd = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready === 1'b1) begin
        rd = cpu_rdata; swe = sram_we; swd = sram_wdata;
        got = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
    $display("cpu %s addr=%h wdata=%h -> rdata=%h cycles=%0d", we ? "ST" : "LD", addr, wd, rd, cyc);
    if (!got) chk("cpu_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [15:0] rd;
    int          cyc;
    logic        swe;
    logic [63:0] swd;
    logic        seen;

    for (int i = 0; i < 16; i++) sram_mem[i] = {4{16'hDEAD}};
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_sram_we", 64'(sram_we), 64'd0);
    rst_n = 1'b1;

    // 1: cold miss on 0x0010
    dram_lat = 3;
    cpu_access(1'b0, 16'h0010, 16'h0, rd, cyc, swe, swd);
    chk("t1_rdata", 64'(rd), 64'h5010);
    chk("t1_nreq", 64'(q_we.size()), 64'd1);
    if (q_we.size() > 0) begin
      chk("t1_mem_we", 64'(q_we.pop_front()), 64'd0);
      chk("t1_mem_addr", 64'(q_addr.pop_front()), 64'h004);
      void'(q_wdata.pop_front());
    end

    // 2: hit, one-cycle latency, no DRAM traffic
    cpu_access(1'b0, 16'h0011, 16'h0, rd, cyc, swe, swd);
    chk("t2_rdata", 64'(rd), 64'h5011);
    chk("t2_latency", 64'(cyc), 64'd1);
    chk("t2_nreq", 64'(q_we.size()), 64'd0);

    // 3: store hit then load back
    cpu_access(1'b1, 16'h0012, 16'hBEEF, rd, cyc, swe, swd);
    chk("t3_st_latency", 64'(cyc), 64'd1);
    chk("t3_sram_we", 64'(swe), 64'd1);
    chk("t3_sram_wdata", swd, 64'h5013_BEEF_5011_5010);
    cpu_access(1'b0, 16'h0012, 16'h0, rd, cyc, swe, swd);
    chk("t3_ld_rdata", 64'(rd), 64'hBEEF);
    chk("t3_nreq", 64'(q_we.size()), 64'd0);

    // 4: conflict miss on dirty line -> write-back then refill
    dram_lat = 2;
    cpu_access(1'b0, 16'h0412, 16'h0, rd, cyc, swe, swd);
    chk("t4_rdata", 64'(rd), 64'h5412);
    chk("t4_nreq", 64'(q_we.size()), 64'd2);
    if (q_we.size() == 2) begin
      chk("t4_wb_we", 64'(q_we.pop_front()), 64'd1);
      chk("t4_wb_addr", 64'(q_addr.pop_front()), 64'h004);
      chk("t4_wb_data", q_wdata.pop_front(), 64'h5013_BEEF_5011_5010);
      chk("t4_rf_we", 64'(q_we.pop_front()), 64'd0);
      chk("t4_rf_addr", 64'(q_addr.pop_front()), 64'h104);
      void'(q_wdata.pop_front());
    end

    // 5: reset while the refill is outstanding
    dram_lat = 10;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_req_seen", 64'(seen), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    cpu_req = 1'b0;
    #1 chk("t5_req_abort", 64'(mem_req), 64'd0);
    chk("t5_ready_abort", 64'(cpu_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q_we.delete(); q_addr.delete(); q_wdata.delete();
    dram_lat = 3;
    cpu_access(1'b0, 16'h0010, 16'h0, rd, cyc, swe, swd);
    chk("t5_rdata", 64'(rd), 64'h5010);
    chk("t5_nreq", 64'(q_we.size()), 64'd1);
    if (q_we.size() > 0) begin
      chk("t5_mem_addr", 64'(q_addr.pop_front()), 64'h004);
      void'(q_we.pop_front()); void'(q_wdata.pop_front());
    end

    // 6: DRAM holds ready low for 20 cycles
    dram_lat = 21;
    cpu_access(1'b0, 16'h0823, 16'h0, rd, cyc, swe, swd);
    chk("t6_rdata", 64'(rd), 64'h5823);
    chk("t6_nreq", 64'(q_we.size()), 64'd1);
    if (q_we.size() > 0) begin
      chk("t6_mem_addr", 64'(q_addr.pop_front()), 64'h208);
      void'(q_we.pop_front()); void'(q_wdata.pop_front());
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
